ascon_decrypt128a: RTL and testbench

//  Iterative Ascon-128a authenticated decryption core; counterpart of the 128a encrypt top.

---
 rtl/ascon_decrypt128a.sv | 243 ++++++++++++++++++++++++
 tb/tb_ascon_decrypt128a.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_decrypt128a.sv
// Ascon-128a authenticated decryption of one AD block and one ciphertext block.
// Iterative permutation core evaluating UNROLL rounds per clock.

module ascon_decrypt128a #(
    parameter int UNROLL          = 1,
    parameter bit RELEASE_ON_FAIL = 1'b0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [127:0] SK,
    input  logic [127:0] N,
    input  logic [127:0] A,
    input  logic [127:0] C,
    input  logic [127:0] T,
    output logic         BUSY,
    output logic         DONE,
    output logic         TAG_OK,
    output logic [127:0] P
);

    localparam logic [63:0] IV    = 64'h80800c0800000000;
    localparam int          CYC12 = 12 / UNROLL;
    localparam int          CYC8  = 8 / UNROLL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ADB,
        S_ADP,
        S_CTB,
        S_FIN,
        S_CMP
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [319:0] s_q, s_d;
    logic [127:0] k_q, k_d;
    logic [127:0] a_q, a_d;
    logic [127:0] c_q, c_d;
    logic [127:0] t_q, t_d;
    logic [127:0] pint_q, pint_d;
    logic [127:0] p_q, p_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         tag_ok_q, tag_ok_d;

    logic         long_phase;
    logic         last_cyc;
    logic [3:0]   base_idx;
    logic [3:0]   step_cnt;
    logic         tag_match;
    logic [3:0]   ridx;
    logic [319:0] rnd;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant addition, bitsliced S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(
        input logic [319:0] s,
        input logic [7:0]   rc
    );
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2 = x2 ^ {56'd0, rc};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1) ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7) ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Phase geometry: p12 starts at constant 0, p8 at constant 4.
    always_comb begin
        long_phase = (state_q == S_INIT) || (state_q == S_FIN);
        base_idx   = long_phase ? 4'd0 : 4'd4;
        if (long_phase) begin
            last_cyc = (cnt_q == 4'(CYC12 - 1));
        end else begin
            last_cyc = (cnt_q == 4'(CYC8 - 1));
        end
        step_cnt  = last_cyc ? 4'd0 : cnt_q + 4'd1;
        tag_match = ((s_q[127:0] ^ k_q) == t_q);
    end

    // Chain UNROLL rounds with consecutive constants from the current count.
    always_comb begin
        rnd  = s_q;
        ridx = 4'd0;
        for (int k = 0; k < UNROLL; k++) begin
            ridx = base_idx + 4'(int'(cnt_q) * UNROLL + k);
            rnd  = ascon_round(rnd, {~ridx, ridx});
        end
    end

    // Sequencer: round phases with boundary XORs applied to the round output.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        k_d      = k_q;
        a_d      = a_q;
        c_d      = c_q;
        t_d      = t_q;
        pint_d   = pint_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tag_ok_d = tag_ok_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d  = S_INIT;
                    cnt_d    = 4'd0;
                    s_d      = {IV, SK, N};
                    k_d      = SK;
                    a_d      = A;
                    c_d      = C;
                    t_d      = T;
                    busy_d   = 1'b1;
                    tag_ok_d = 1'b0;
                    p_d      = '0;
                end
            end
            S_INIT: begin
                s_d   = rnd;
                cnt_d = step_cnt;
                if (last_cyc) begin
                    state_d       = S_ADB;
                    s_d[127:0]    = rnd[127:0] ^ k_q;
                    s_d[319:192]  = rnd[319:192] ^ a_q;
                end
            end
            S_ADB: begin
                s_d   = rnd;
                cnt_d = step_cnt;
                if (last_cyc) begin
                    state_d  = S_ADP;
                    s_d[319] = ~rnd[319];
                end
            end
            S_ADP: begin
                s_d   = rnd;
                cnt_d = step_cnt;
                if (last_cyc) begin
                    state_d      = S_CTB;
                    s_d[0]       = ~rnd[0];
                    pint_d       = rnd[319:192] ^ c_q;
                    s_d[319:192] = c_q;
                end
            end
            S_CTB: begin
                s_d   = rnd;
                cnt_d = step_cnt;
                if (last_cyc) begin
                    state_d     = S_FIN;
                    s_d[319]    = ~rnd[319];
                    s_d[191:64] = rnd[191:64] ^ k_q;
                end
            end
            S_FIN: begin
                s_d   = rnd;
                cnt_d = step_cnt;
                if (last_cyc) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                tag_ok_d = tag_match;
                p_d      = (tag_match || RELEASE_ON_FAIL) ? pint_q : '0;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            s_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            c_q      <= '0;
            t_q      <= '0;
            pint_q   <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tag_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            k_q      <= k_d;
            a_q      <= a_d;
            c_q      <= c_d;
            t_q      <= t_d;
            pint_q   <= pint_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tag_ok_q <= tag_ok_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign TAG_OK = tag_ok_q;
    assign P      = p_q;

endmodule

// File: tb/tb_ascon_decrypt128a.sv
// Testbench for ascon_decrypt128a: reference Ascon-128a encryption model
// produces ciphertext and tag, decryption cores must recover plaintext.

module tb_ascon_decrypt128a;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] N0 = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A0 = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [127:0] P0 = 128'h303132333435363738393a3b3c3d3e3f;
    localparam logic [127:0] B127 = {1'b1, 127'd0};

    logic CLK = 1'b0;
    logic RST;
    logic st1, st2, st4;
    logic [127:0] in_sk, in_n, in_a, in_c, in_t;
    logic [127:0] c0, t0;

    logic d1_busy, d1_done, d1_tok;
    logic d1r_busy, d1r_done, d1r_tok;
    logic d2_busy, d2_done, d2_tok;
    logic d4_busy, d4_done, d4_tok;
    logic [127:0] d1_p, d1r_p, d2_p, d4_p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    ascon_decrypt128a #(.UNROLL(1), .RELEASE_ON_FAIL(1'b0)) d1 (
        .CLK(CLK), .RST(RST), .START(st1), .SK(in_sk), .N(in_n), .A(in_a),
        .C(in_c), .T(in_t), .BUSY(d1_busy), .DONE(d1_done), .TAG_OK(d1_tok), .P(d1_p));
    ascon_decrypt128a #(.UNROLL(1), .RELEASE_ON_FAIL(1'b1)) d1r (
        .CLK(CLK), .RST(RST), .START(st1), .SK(in_sk), .N(in_n), .A(in_a),
        .C(in_c), .T(in_t), .BUSY(d1r_busy), .DONE(d1r_done), .TAG_OK(d1r_tok), .P(d1r_p));
    ascon_decrypt128a #(.UNROLL(2), .RELEASE_ON_FAIL(1'b0)) d2 (
        .CLK(CLK), .RST(RST), .START(st2), .SK(in_sk), .N(in_n), .A(in_a),
        .C(in_c), .T(in_t), .BUSY(d2_busy), .DONE(d2_done), .TAG_OK(d2_tok), .P(d2_p));
    ascon_decrypt128a #(.UNROLL(4), .RELEASE_ON_FAIL(1'b0)) d4 (
        .CLK(CLK), .RST(RST), .START(st4), .SK(in_sk), .N(in_n), .A(in_a),
        .C(in_c), .T(in_t), .BUSY(d4_busy), .DONE(d4_done), .TAG_OK(d4_tok), .P(d4_p));

    // ---------------- reference model (table S-box, word arrays) ----------------
    function automatic logic [4:0] sbox(input logic [4:0] v);
        logic [159:0] tbl;
        tbl = {5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
               5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
               5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
               5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04};
        return tbl[int'(v) * 5 +: 5];
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [4:0] v, o;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                for (int i = 0; i < 5; i++) v[4 - i] = x[i][b];
                o = sbox(v);
                for (int i = 0; i < 5; i++) x[i][b] = o[4 - i];
            end
            x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
            x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
            x[2] = x[2] ^ ror(x[2], 1) ^ ror(x[2], 6);
            x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
            x[4] = x[4] ^ ror(x[4], 7) ^ ror(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Ascon-128a encryption of one AD block and one plaintext block.
    task automatic enc(input logic [127:0] k, nn, aa, pp, output logic [127:0] cc, tt);
        logic [319:0] s;
        s = {64'h80800c0800000000, k, nn};
        s = perm(s, 12);
        s[127:0] = s[127:0] ^ k;
        s[319:192] = s[319:192] ^ aa;
        s = perm(s, 8);
        s[319:192] = s[319:192] ^ B127;
        s = perm(s, 8);
        s[0] = s[0] ^ 1'b1;
        cc = s[319:192] ^ pp;
        s[319:192] = cc;
        s = perm(s, 8);
        s[319] = s[319] ^ 1'b1;
        s[191:64] = s[191:64] ^ k;
        s = perm(s, 12);
        tt = s[127:0] ^ k;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_in(input logic [127:0] k, nn, aa, cc, tt);
        in_sk = k; in_n = nn; in_a = aa; in_c = cc; in_t = tt;
    endtask

    task automatic set_start(input int g, input logic v);
        case (g)
            1: st1 = v;
            2: st2 = v;
            default: st4 = v;
        endcase
    endtask

    function automatic logic done_of(input int g);
        case (g)
            1: return d1_done;
            2: return d2_done;
            default: return d4_done;
        endcase
    endfunction

    function automatic logic busy_of(input int g);
        case (g)
            1: return d1_busy;
            2: return d2_busy;
            default: return d4_busy;
        endcase
    endfunction

    // Pulse START for one cycle; lat = edges after accept until DONE (-1 on timeout).
    task automatic run_job(input int g, input int bound, output int lat, output logic busy1);
        set_start(g, 1'b1);
        @(posedge CLK); #1;
        set_start(g, 1'b0);
        lat = -1;
        busy1 = 1'b0;
        for (int i = 1; i <= bound; i++) begin
            @(posedge CLK); #1;
            if (i == 1) busy1 = busy_of(g);
            if (done_of(g)) begin
                lat = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++; if (d1_busy !== 1'b0 || d1_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl busy=%b done=%b exp 0 0", d1_busy, d1_done); end
        checks++; if (d1_tok !== 1'b0) begin errors++; $display("FAIL reset_tagok got=%b exp=0", d1_tok); end
        checks++; if (d1_p !== 128'd0) begin errors++; $display("FAIL reset_p got=%h exp=0", d1_p); end
        checks++; if (d4_busy !== 1'b0 || d4_p !== 128'd0) begin errors++; $display("FAIL reset_u4 busy=%b p=%h exp 0", d4_busy, d4_p); end
    endtask

    task automatic test_roundtrip();
        int lat;
        logic b1;
        set_in(K0, N0, A0, c0, t0);
        run_job(1, 80, lat, b1);
        checks++; if (lat !== 49) begin errors++; $display("FAIL rt_latency got=%0d exp=49", lat); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL rt_busy got=%b exp=1", b1); end
        checks++; if (d1_tok !== 1'b1) begin errors++; $display("FAIL rt_tagok got=%b exp=1", d1_tok); end
        checks++; if (d1_p !== P0) begin errors++; $display("FAIL rt_p got=%h exp=%h", d1_p, P0); end
        checks++; if (d1r_done !== 1'b1 || d1r_tok !== 1'b1 || d1r_p !== P0) begin errors++; $display("FAIL rt_release done=%b tok=%b p=%h exp 1 1 %h", d1r_done, d1r_tok, d1r_p, P0); end
        @(posedge CLK); #1;
        checks++; if (d1_done !== 1'b0 || d1_busy !== 1'b0) begin errors++; $display("FAIL rt_pulse done=%b busy=%b exp 0 0", d1_done, d1_busy); end
        checks++; if (d1_p !== P0 || d1_tok !== 1'b1) begin errors++; $display("FAIL rt_hold p=%h tok=%b exp %h 1", d1_p, d1_tok, P0); end
    endtask

    task automatic test_tag_tamper();
        int lat;
        logic b1;
        set_in(K0, N0, A0, c0, t0 ^ 128'd1);
        run_job(1, 80, lat, b1);
        checks++; if (lat !== 49) begin errors++; $display("FAIL tt_latency got=%0d exp=49", lat); end
        checks++; if (d1_tok !== 1'b0 || d1_p !== 128'd0) begin errors++; $display("FAIL tt_blocked tok=%b p=%h exp 0 0", d1_tok, d1_p); end
        checks++; if (d1r_tok !== 1'b0 || d1r_p !== P0) begin errors++; $display("FAIL tt_released tok=%b p=%h exp 0 %h", d1r_tok, d1r_p, P0); end
    endtask

    task automatic test_ct_tamper();
        int lat;
        logic b1;
        set_in(K0, N0, A0, c0 ^ B127, t0);
        run_job(1, 80, lat, b1);
        checks++; if (d1_tok !== 1'b0 || d1_p !== 128'd0) begin errors++; $display("FAIL ct_blocked tok=%b p=%h exp 0 0", d1_tok, d1_p); end
        checks++; if (d1r_tok !== 1'b0 || d1r_p !== (P0 ^ B127)) begin errors++; $display("FAIL ct_released tok=%b p=%h exp 0 %h", d1r_tok, d1r_p, P0 ^ B127); end
    endtask

    task automatic test_reset_midop();
        int lat;
        int pulses;
        logic b1;
        set_in(K0, N0, A0, c0, t0);
        st1 = 1'b1;
        @(posedge CLK); #1;
        st1 = 1'b0;
        repeat (19) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++; if (d1_busy !== 1'b0 || d1r_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b/%b exp=0", d1_busy, d1r_busy); end
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge CLK); #1;
            if (d1_done === 1'b1 || d1r_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_nodone got=%0d pulses exp=0", pulses); end
        run_job(1, 80, lat, b1);
        checks++; if (lat !== 49) begin errors++; $display("FAIL mid_relat got=%0d exp=49", lat); end
        checks++; if (d1_tok !== 1'b1 || d1_p !== P0) begin errors++; $display("FAIL mid_result tok=%b p=%h exp 1 %h", d1_tok, d1_p, P0); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int first;
        int second;
        set_in(K0, N0, A0, c0, t0);
        st1 = 1'b1;
        @(posedge CLK); #1;
        st1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge CLK); #1;
            if (d1_done) begin
                lat = i;
                break;
            end
            st1 = (i == 5 || i == 30);
            if (i == 10) set_in(rnd128(), rnd128(), rnd128(), rnd128(), rnd128());
        end
        st1 = 1'b0;
        checks++; if (lat !== 49) begin errors++; $display("FAIL bi_latency got=%0d exp=49", lat); end
        checks++; if (d1_tok !== 1'b1 || d1_p !== P0) begin errors++; $display("FAIL bi_result tok=%b p=%h exp 1 %h", d1_tok, d1_p, P0); end
        set_in(K0, N0, A0, c0, t0);
        st1 = 1'b1;
        first = -1;
        second = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK); #1;
            if (d1_done) begin
                if (first < 0) begin
                    first = cyc;
                end else begin
                    second = cyc;
                    break;
                end
            end
        end
        st1 = 1'b0;
        checks++; if (first < 0 || second < 0 || (second - first) !== 50) begin errors++; $display("FAIL bi_held first=%0d second=%0d exp spacing 50", first, second); end
        checks++; if (d1_tok !== 1'b1 || d1_p !== P0) begin errors++; $display("FAIL bi_held_result tok=%b p=%h exp 1 %h", d1_tok, d1_p, P0); end
        @(posedge CLK); #1;
    endtask

    task automatic test_unroll();
        int lat;
        logic b1;
        set_in(K0, N0, A0, c0, t0);
        run_job(2, 60, lat, b1);
        checks++; if (lat !== 25) begin errors++; $display("FAIL u2_latency got=%0d exp=25", lat); end
        checks++; if (d2_tok !== 1'b1 || d2_p !== P0) begin errors++; $display("FAIL u2_result tok=%b p=%h exp 1 %h", d2_tok, d2_p, P0); end
        run_job(4, 60, lat, b1);
        checks++; if (lat !== 13) begin errors++; $display("FAIL u4_latency got=%0d exp=13", lat); end
        checks++; if (d4_tok !== 1'b1 || d4_p !== P0) begin errors++; $display("FAIL u4_result tok=%b p=%h exp 1 %h", d4_tok, d4_p, P0); end
        set_in(K0, N0, A0, c0, t0 ^ (128'd1 << 64));
        run_job(4, 60, lat, b1);
        checks++; if (d4_tok !== 1'b0 || d4_p !== 128'd0) begin errors++; $display("FAIL u4_tamper tok=%b p=%h exp 0 0", d4_tok, d4_p); end
    endtask

    task automatic test_random();
        logic [127:0] k, nn, aa, pp, cc, tt, cx, tx, m;
        logic exp_ok;
        logic [127:0] exp_p, exp_pr;
        int mode;
        int lat;
        logic b1;
        for (int it = 0; it < 8; it++) begin
            k = rnd128(); nn = rnd128(); aa = rnd128(); pp = rnd128();
            enc(k, nn, aa, pp, cc, tt);
            mode = (it == 0) ? 0 : int'($urandom_range(0, 2));
            m = 128'd1 << $urandom_range(0, 127);
            cx = (mode == 2) ? (cc ^ m) : cc;
            tx = (mode == 1) ? (tt ^ m) : tt;
            exp_ok = (mode == 0);
            exp_p = exp_ok ? pp : 128'd0;
            exp_pr = pp ^ cx ^ cc;
            set_in(k, nn, aa, cx, tx);
            run_job(1, 80, lat, b1);
            checks++; if (lat !== 49) begin errors++; $display("FAIL rnd%0d_lat got=%0d exp=49", it, lat); end
            checks++; if (d1_tok !== exp_ok || d1_p !== exp_p) begin errors++; $display("FAIL rnd%0d_u1 tok=%b p=%h exp %b %h", it, d1_tok, d1_p, exp_ok, exp_p); end
            checks++; if (d1r_tok !== exp_ok || d1r_p !== exp_pr) begin errors++; $display("FAIL rnd%0d_rel tok=%b p=%h exp %b %h", it, d1r_tok, d1r_p, exp_ok, exp_pr); end
            run_job(2, 60, lat, b1);
            checks++; if (lat !== 25 || d2_tok !== exp_ok || d2_p !== exp_p) begin errors++; $display("FAIL rnd%0d_u2 lat=%0d tok=%b p=%h exp 25 %b %h", it, lat, d2_tok, d2_p, exp_ok, exp_p); end
            run_job(4, 60, lat, b1);
            checks++; if (lat !== 13 || d4_tok !== exp_ok || d4_p !== exp_p) begin errors++; $display("FAIL rnd%0d_u4 lat=%0d tok=%b p=%h exp 13 %b %h", it, lat, d4_tok, d4_p, exp_ok, exp_p); end
        end
    endtask

    initial begin
        RST = 1'b1;
        st1 = 1'b0;
        st2 = 1'b0;
        st4 = 1'b0;
        set_in('0, '0, '0, '0, '0);
        enc(K0, N0, A0, P0, c0, t0);
        test_reset();
        test_roundtrip();
        test_tag_tamper();
        test_ct_tamper();
        test_reset_midop();
        test_busy_ignore();
        test_unroll();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
